// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states
// and default latencies.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit with private HI/LO and counter-modelled latency.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise those ops are ignored.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = 16;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [63:0]        res;
  logic               wr;

  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        q_s, r_s, q_u, r_u;
  logic               div_zero, div_ovf, op_ok, accept;
  logic [63:0]        next_res;
  logic               next_wr, long_op, is_div;

  assign a_sx     = {{32{a[31]}}, a};
  assign b_sx     = {{32{b[31]}}, b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hffff_ffff);

  // The overflow case is pinned explicitly rather than left to the divider.
  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!div_zero) begin
      q_u = a / b;
      r_u = a % b;
      if (div_ovf) begin
        q_s = 32'h8000_0000;
      end else begin
        q_s = $unsigned($signed(a) / $signed(b));
        r_s = $unsigned($signed(a) % $signed(b));
      end
    end
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc_s, acc_u;
  assign acc_s = {hi, lo} + prod_s;
  assign acc_u = {hi, lo} + prod_u;
  assign op_ok = 1'b1;
`else
  assign op_ok = (op != MDU_MADD) && (op != MDU_MADDU);
`endif

  assign accept = start && !cancel && (state == IDLE) && op_ok;

  always_comb begin
    next_res = '0;
    next_wr  = 1'b0;
    long_op  = 1'b0;
    is_div   = 1'b0;
    case (op)
      MDU_MULT:  begin next_res = prod_s;     next_wr = 1'b1;      long_op = 1'b1; end
      MDU_MULTU: begin next_res = prod_u;     next_wr = 1'b1;      long_op = 1'b1; end
      MDU_DIV:   begin next_res = {r_s, q_s}; next_wr = !div_zero; long_op = 1'b1; is_div = 1'b1; end
      MDU_DIVU:  begin next_res = {r_u, q_u}; next_wr = !div_zero; long_op = 1'b1; is_div = 1'b1; end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin next_res = acc_s;      next_wr = 1'b1;      long_op = 1'b1; end
      MDU_MADDU: begin next_res = acc_u;      next_wr = 1'b1;      long_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      wr    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end else if (long_op) begin
              res   <= next_res;
              wr    <= next_wr;
              cnt   <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
              state <= BUSY;
              busy  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (wr) {hi, lo} <= res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes expected HI/LO with a due cycle,
// a negedge monitor checks busy every cycle and pops due entries.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .op(op), .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] h;
    logic [31:0] l;
  } item_t;

  item_t       sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          run = 1'b0;
  int          busy_start = 0;
  int          busy_end = -1;
  logic [31:0] mhi = '0, mlo = '0, ohi = '0, olo = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit op_valid(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return o < 3'd6;
`endif
  endfunction

  // Reference behaviour from the architectural definitions, using plain integer arithmetic.
  task automatic model_exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output bit wr, output logic [63:0] r, output int n);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              ix, iy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ix = x;
    iy = y;
    wr = 1'b1;
    r  = '0;
    n  = 5;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: begin
        n = 10;
        if (y == 0) wr = 1'b0;
        else if (x == 32'h8000_0000 && y == 32'hffff_ffff) r = {32'h0, 32'h8000_0000};
        else r = {32'(ix % iy), 32'(ix / iy)};
      end
      3'd3: begin
        n = 10;
        if (y == 0) wr = 1'b0;
        else r = {x % y, x / y};
      end
      3'd6: r = {mhi, mlo} + 64'(sx * sy);
      default: r = {mhi, mlo} + 64'(ux * uy);
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic cn);
    int          t, n;
    bit          acc, wr;
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cancel = cn;
    t   = cyc + 1;
    acc = !cn && (t > busy_end) && op_valid(o);
    if (!acc) begin
      if (t >= busy_end) sb.push_back('{t, mhi, mlo});
      else               sb.push_back('{t, ohi, olo});
    end else if (o == 3'd4 || o == 3'd5) begin
      if (o == 3'd4) mhi = x; else mlo = x;
      ohi = mhi; olo = mlo;
      sb.push_back('{t, mhi, mlo});
    end else begin
      model_exec(o, x, y, wr, r, n);
      ohi = mhi; olo = mlo;
      if (wr) {mhi, mlo} = r;
      busy_start = t;
      busy_end   = t + n;
      sb.push_back('{t + n, mhi, mlo});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic pulse_reset();
    int old_end;
    old_end = busy_end;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    sb.delete();
    mhi = '0; mlo = '0; ohi = '0; olo = '0;
    busy_start = 0;
    busy_end   = -1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.push_back('{old_end + 2, 32'd0, 32'd0});
  endtask

  always @(negedge clk) begin
    logic eb;
    if (run && !reset) begin
      eb = (cyc >= busy_start) && (cyc < busy_end);
      check("busy", {63'd0, busy}, {63'd0, eb});
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          check("hilo", {hi, lo}, {sb[i].h, sb[i].l});
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    logic        cn;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    run = 1'b1;

    issue(3'd0, 32'hffff_fffe, 32'd3, 1'b0);
    repeat (6) @(negedge clk);
    check("mult_const", {hi, lo}, {32'hffff_ffff, 32'hffff_fffa});
    issue(3'd1, 32'hffff_fffe, 32'd3, 1'b0);
    repeat (6) @(negedge clk);
    check("multu_const", {hi, lo}, {32'h0000_0002, 32'hffff_fffa});
    issue(3'd2, 32'hffff_fff9, 32'd2, 1'b0);
    repeat (11) @(negedge clk);
    check("div_const", {hi, lo}, {32'hffff_ffff, 32'hffff_fffd});
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    repeat (11) @(negedge clk);
    check("divu_zero_const", {hi, lo}, {32'hffff_ffff, 32'hffff_fffd});
    issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    issue(3'd5, 32'h9abc_def0, 32'd0, 1'b0);
    @(negedge clk);
    check("mt_const", {hi, lo}, {32'h1234_5678, 32'h9abc_def0});

    issue(3'd0, 32'd5, 32'd7, 1'b0);
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    repeat (6) @(negedge clk);
    check("start_while_busy", {hi, lo}, {32'd0, 32'd35});
    issue(3'd2, 32'd100, 32'd3, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    repeat (11) @(negedge clk);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

    issue(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    pulse_reset();
    repeat (14) @(negedge clk);

    issue(3'd4, 32'd0, 32'd0, 1'b0);
    issue(3'd5, 32'hffff_ffff, 32'd0, 1'b0);
    issue(3'd7, 32'd1, 32'd1, 1'b0);
    repeat (6) @(negedge clk);
`ifdef MDU_MADD_EN
    check("maddu_const", {hi, lo}, {32'd1, 32'd0});
`else
    check("op7_ignored", {hi, lo}, {32'd0, 32'hffff_ffff});
`endif

    for (int i = 0; i < 80; i++) begin
      o  = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      cn = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hffff_ffff; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(o, x, y, cn);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    repeat (16) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the execute stage of the pipelined MIPS core, beside the ALU. It takes the same forwarded operands the ALU uses (rs value and rt value, after the extended-immediate / register select) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO into private HI/LO registers. It models the fixed multi-cycle latency with a busy flag; the hazard unit uses that flag to stall the decode stage.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for multiply-class ops (≥1)
- DIV_CYCLES, 10, busy cycles for divide-class ops (≥1)

Ports:
- clk  in  1  single clock, rising edge; the block has one clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  execute-stage instruction is an MDU op
- cancel  in  1  older instruction faulting in memory stage; suppresses start
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
- a  in  32  rs operand
- b  in  32  rt operand
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Reset state is IDLE with busy=0, hi=0, lo=0, counter=0.
- Start is accepted at a rising edge when start=1, cancel=0 and busy=0. If busy=1 or cancel=1, start is ignored; the hazard unit must not issue into a busy MDU.
- MULT: signed 32×32→64, result {hi,lo}. MULTU: unsigned.
- DIV: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (b=0): HI/LO keep their values. The full busy period still elapses.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
- MTHI/MTLO: hi or lo takes the value of a at the accepting edge. Busy stays 0 and the other register is unchanged.
- Op 6/7 without MDU_MADD_EN: start is ignored, with no state change.
- The result is computed from a and b latched at the accepting edge. It is held in an internal 64-bit result register and copied to hi/lo at the end of the busy period.
- cancel has no effect on an operation already in BUSY.

## Timing
- Accept at edge T: busy=1 from T until edge T+N, where N=MULT_CYCLES or DIV_CYCLES. busy reads 1 for exactly N cycles.
- hi/lo update at edge T+N, the same edge at which busy falls. hi/lo are unchanged throughout BUSY.
- A new start can be accepted at edge T+N+1 at the earliest. Back-to-back ops therefore have an issue interval of N+1.
- MTHI/MTLO: visible at the cycle after edge T, with no busy.
- Reset asserted mid-BUSY: busy, hi, lo and the counter clear immediately. The pending result is discarded.
- Simultaneous start=1 and cancel=1: start is not accepted.

## Configuration
- MDU_MADD_EN defined:
  - op 6 MADD adds the signed product to {hi,lo}, modulo 2^64.
  - op 7 MADDU adds the unsigned product, modulo 2^64.
  - Latency is MULT_CYCLES.
  - The accumulate base is the {hi,lo} value at the accepting edge.
- Undefined: ops 6/7 are ignored as described above, and no accumulate adder is built.

## Structure
- Shared package mdu_pkg holds:
  - op code constants (MDU_MULT … MDU_MADDU)
  - state encoding (IDLE, BUSY)
  - default cycle counts
- No sub-module: the counter, result register and arithmetic stay inline. Division uses combinational / and % on the latched operands. An iterative divider is not required because the latency is modelled by the counter.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 after reset → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → busy high for 10 cycles; hi/lo unchanged.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → busy never rises; hi/lo read those values one cycle after each start.
- MULT started, then start=1 with DIV on the 2nd busy cycle → the DIV is ignored; only the MULT result appears, at cycle 5. start with cancel=1 → no busy, no change.
- reset pulsed on the 3rd cycle of DIV → busy=0 and hi=lo=0 immediately; no late write follows.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro, op 6 → no busy and no change.
